// File: rtl/mem_access.sv
// mem_access -- MEM pipeline stage with a handshaked data-memory port.
//
// Non-memory instructions pass straight through with zero latency. A load or
// store stalls the upstream stages. The stage latches the request, holds
// dmem_req until dmem_ready, and then presents the result for one DONE cycle.
//
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a BUSY cycle
// counter aborts a request that gets no dmem_ready within TIMEOUT_CYC cycles.
// An aborted request returns readdata=16'hFFFF, forces regwrite=0 and pulses
// mem_err.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   in_valid, memread_in, memwrite_in, regwrite_in, memtoreg_in,
//   alu_result_in, writedata_in, ins_wr_in
//                                 EX/MEM register contents
//   stall                         holds the upstream stages
//   dmem_req, dmem_we, dmem_addr, dmem_wdata
//                                 data-memory request
//   dmem_rdata, dmem_ready        data-memory response
//   regwrite, memtoreg, readdata, ALU_result, ins_wr
//                                 to the MEM/WB register
//   mem_err                       one-cycle timeout pulse
module mem_access #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] writedata_in,
  input  logic [2:0]  ins_wr_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        regwrite,
  output logic        memtoreg,
  output logic [15:0] readdata,
  output logic [15:0] ALU_result,
  output logic [2:0]  ins_wr,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        we_r;
  logic        regwrite_r;
  logic        memtoreg_r;
  logic [2:0]  ins_wr_r;
  logic [15:0] rdata_r;
  logic        mem_op_s;
  logic        timeout_s;

`ifdef MEM_TIMEOUT_EN
  localparam logic [4:0] LAST_CNT = 5'(TIMEOUT_CYC - 1);
  logic [4:0] cnt_r;
  logic       tout_r;

  // The final BUSY cycle arrives without a response.
  assign timeout_s = (cnt_r == LAST_CNT) && !dmem_ready;
`else
  logic [4:0] timeout_unused_s;

  assign timeout_unused_s = 5'(TIMEOUT_CYC);
  assign timeout_s        = 1'b0;
`endif

  // A valid instruction that touches memory must enter the handshake.
  assign mem_op_s = in_valid && (memread_in || memwrite_in);

  // State register, request latch, read-data capture and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      addr_r     <= 16'h0000;
      wdata_r    <= 16'h0000;
      we_r       <= 1'b0;
      regwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      ins_wr_r   <= 3'd0;
      rdata_r    <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      cnt_r      <= 5'd0;
      tout_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            addr_r     <= alu_result_in;
            wdata_r    <= writedata_in;
            // A simultaneous read and write is treated as a write.
            we_r       <= memwrite_in;
            regwrite_r <= regwrite_in;
            memtoreg_r <= memtoreg_in;
            ins_wr_r   <= ins_wr_in;
            rdata_r    <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            cnt_r      <= 5'd0;
            tout_r     <= 1'b0;
`endif
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            // A write leaves readdata at zero.
            if (!we_r) begin
              rdata_r <= dmem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_s) begin
            rdata_r <= 16'hFFFF;
            tout_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (dmem_ready || timeout_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode. Reset is included here so that a reset takes effect
  // immediately, even while the upstream still presents a memory op.
  always_comb begin
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = addr_r;
    dmem_wdata = wdata_r;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    readdata   = 16'h0000;
    ALU_result = 16'h0000;
    ins_wr     = 3'd0;
    mem_err    = 1'b0;
    if (!reset) begin
      stall = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            stall = 1'b1;
          end else begin
            regwrite   = in_valid && regwrite_in;
            memtoreg   = memtoreg_in;
            ALU_result = alu_result_in;
            ins_wr     = ins_wr_in;
          end
        end
        BUSY: begin
          stall    = 1'b1;
          dmem_req = 1'b1;
          dmem_we  = we_r;
        end
        DONE: begin
          memtoreg   = memtoreg_r;
          readdata   = rdata_r;
          ALU_result = addr_r;
          ins_wr     = ins_wr_r;
`ifdef MEM_TIMEOUT_EN
          regwrite   = regwrite_r && !tout_r;
          mem_err    = tout_r;
`else
          regwrite   = regwrite_r;
`endif
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed bench for mem_access with a transaction-level model.
//
// run_op applies one instruction and expands it into the cycle-by-cycle
// outputs that the stage must show. A single negedge process compares the DUT
// against these outputs. Literal checks after each operation pin the model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, memread_in, memwrite_in, regwrite_in, memtoreg_in;
  logic [15:0] alu_result_in, writedata_in;
  logic [2:0]  ins_wr_in;
  logic        stall, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        regwrite, memtoreg, mem_err;
  logic [15:0] readdata, ALU_result;
  logic [2:0]  ins_wr;

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO_CYC = 16;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .alu_result_in(alu_result_in), .writedata_in(writedata_in), .ins_wr_in(ins_wr_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .regwrite(regwrite), .memtoreg(memtoreg), .readdata(readdata),
    .ALU_result(ALU_result), .ins_wr(ins_wr), .mem_err(mem_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle.
  logic        exp_on = 1'b0;
  logic        e_stall, e_req, e_we, e_rw, e_err, e_mtr, chk_bus, chk_data;
  logic [15:0] e_addr, e_wdata, e_rd, e_alu;
  logic [2:0]  e_iw;

  // Observations gathered over one operation, used by the literal checks.
  int          stall_cnt, we_cnt;
  logic        req_seen, last_rw, last_mtr, last_err;
  logic [15:0] last_rd, last_alu, we_wdata;
  logic [2:0]  last_iw;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare the DUT against the model on every cycle that has an expectation.
  always @(negedge clk) begin
    if (exp_on) begin
      chk("stall", {15'd0, stall}, {15'd0, e_stall});
      chk("dmem_req", {15'd0, dmem_req}, {15'd0, e_req});
      chk("dmem_we", {15'd0, dmem_we}, {15'd0, e_we});
      chk("regwrite", {15'd0, regwrite}, {15'd0, e_rw});
      chk("mem_err", {15'd0, mem_err}, {15'd0, e_err});
      if (chk_bus) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (chk_data) begin
        chk("readdata", readdata, e_rd);
        chk("ALU_result", ALU_result, e_alu);
        chk("memtoreg", {15'd0, memtoreg}, {15'd0, e_mtr});
        chk("ins_wr", {13'd0, ins_wr}, {13'd0, e_iw});
      end
    end
  end

  // Completes one clock cycle and records what was observed in it. The task
  // starts just after a rising edge and returns just after the next one.
  task automatic cyc();
    @(negedge clk);
    #1;
    if (stall) stall_cnt++;
    if (dmem_req) req_seen = 1'b1;
    if (dmem_we) begin
      we_cnt++;
      we_wdata = dmem_wdata;
    end
    last_rw  = regwrite;
    last_mtr = memtoreg;
    last_err = mem_err;
    last_rd  = readdata;
    last_alu = ALU_result;
    last_iw  = ins_wr;
    @(posedge clk);
    #1;
  endtask

  // Applies one instruction and expects the outputs cycle by cycle. nwait is
  // the number of BUSY cycles with dmem_ready=0 before the memory responds.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic rw,
                        input logic mtr, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [2:0] iw, input int nwait, input logic [15:0] rdata);
    bit tmo;
    int nbusy;
    in_valid = v; memread_in = rd; memwrite_in = wr; regwrite_in = rw;
    memtoreg_in = mtr; alu_result_in = alu; writedata_in = wd; ins_wr_in = iw;
    dmem_ready = 1'b0; dmem_rdata = rdata;
    stall_cnt = 0; we_cnt = 0; req_seen = 1'b0; we_wdata = 16'h0000;
    e_alu = alu; e_mtr = mtr; e_iw = iw; e_addr = alu; e_wdata = wd; e_err = 1'b0;
    exp_on = 1'b1;
    if (!(v && (rd || wr))) begin
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_rw = v && rw;
      chk_bus = 1'b0; chk_data = 1'b1; e_rd = 16'h0000;
      cyc();
    end else begin
      tmo   = TMO_EN && (nwait >= TMO_CYC);
      nbusy = tmo ? TMO_CYC : nwait + 1;
      // First cycle: request seen in IDLE, stall only.
      e_stall = 1'b1; e_req = 1'b0; e_we = 1'b0; e_rw = 1'b0;
      chk_bus = 1'b0; chk_data = 1'b0;
      cyc();
      for (int i = 0; i < nbusy; i++) begin
        dmem_ready = !tmo && (i == nwait);
        e_req = 1'b1; e_we = wr; chk_bus = 1'b1;
        cyc();
      end
      // Result cycle: the inputs are still presented and must be ignored.
      dmem_ready = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; chk_bus = 1'b0; chk_data = 1'b1;
      e_rw  = tmo ? 1'b0 : rw;
      e_rd  = tmo ? 16'hFFFF : ((rd && !wr) ? rdata : 16'h0000);
      e_err = tmo;
      cyc();
    end
    exp_on = 1'b0;
    in_valid = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
  endtask

  // Watchdog: this should never fire.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Main directed sequence.
  initial begin
    reset = 1'b0;
    in_valid = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0; regwrite_in = 1'b1;
    memtoreg_in = 1'b1; alu_result_in = 16'h0040; writedata_in = 16'h0000;
    ins_wr_in = 3'd1; dmem_rdata = 16'h0000; dmem_ready = 1'b0;
    #12;
    // Reset state with a load presented at the inputs.
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_req", {15'd0, dmem_req}, 16'd0);
    chk("rst_we", {15'd0, dmem_we}, 16'd0);
    chk("rst_regwrite", {15'd0, regwrite}, 16'd0);
    chk("rst_memtoreg", {15'd0, memtoreg}, 16'd0);
    chk("rst_mem_err", {15'd0, mem_err}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load from 0x0040, ready in the 3rd BUSY cycle. This is the first
    // instruction after the reset release.
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd2, 2, 16'hBEEF);
    chk("load_stall_lit", 16'(stall_cnt), 16'd4);
    chk("load_rdata_lit", last_rd, 16'hBEEF);
    chk("load_mtr_lit", {15'd0, last_mtr}, 16'd1);
    chk("load_rw_lit", {15'd0, last_rw}, 16'd1);

    // ALU op.
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd5, 0, 16'h0000);
    chk("alu_stall_lit", 16'(stall_cnt), 16'd0);
    chk("alu_req_lit", {15'd0, req_seen}, 16'd0);
    chk("alu_result_lit", last_alu, 16'h1234);
    chk("alu_rw_lit", {15'd0, last_rw}, 16'd1);
    chk("alu_iw_lit", {13'd0, last_iw}, 16'd5);

    // Store of 0xA5A5 to 0x0010 with immediate ready.
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 3'd0, 0, 16'h0000);
    chk("st_stall_lit", 16'(stall_cnt), 16'd2);
    chk("st_we_cnt_lit", 16'(we_cnt), 16'd1);
    chk("st_wdata_lit", we_wdata, 16'hA5A5);
    chk("st_rw_lit", {15'd0, last_rw}, 16'd0);

    // Read and write together: performed as a write, readdata is zero.
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0022, 16'h1111, 3'd3, 1, 16'h7777);
    chk("rdwr_rdata_lit", last_rd, 16'h0000);
    // A bubble passes through with regwrite gated off.
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h55AA, 16'h0000, 3'd7, 0, 16'h0000);
    chk("bubble_rw_lit", {15'd0, last_rw}, 16'd0);
    // Zero-wait load, then a long wait (aborts when the timeout is enabled).
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0F00, 16'h0000, 3'd4, 0, 16'h0F0F);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0000, 3'd6, 20, 16'h3C3C);
`ifdef MEM_TIMEOUT_EN
    chk("tmo_err_lit", {15'd0, last_err}, 16'd1);
    chk("tmo_rdata_lit", last_rd, 16'hFFFF);
    chk("tmo_stall_lit", 16'(stall_cnt), 16'd17);
`else
    chk("long_rdata_lit", last_rd, 16'h3C3C);
    chk("long_stall_lit", 16'(stall_cnt), 16'd22);
`endif

    // Reset asserted during the 2nd BUSY cycle of a load.
    in_valid = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0; regwrite_in = 1'b1;
    alu_result_in = 16'h0100; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_req_before", {15'd0, dmem_req}, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_req_async", {15'd0, dmem_req}, 16'd0);
    chk("mid_stall_async", {15'd0, stall}, 16'd0);
    chk("mid_rw_async", {15'd0, regwrite}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0; memread_in = 1'b0;
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCAFE, 16'h0000, 3'd3, 0, 16'h0000);
    chk("post_rst_alu_lit", last_alu, 16'hCAFE);
    chk("post_rst_rw_lit", {15'd0, last_rw}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
